// File: rtl/fpnew_pkg.sv
// Minimal FPU package: IEEE-754 exception status word as returned by the FPU.
package fpnew_pkg;

  typedef struct packed {
    logic NV; // invalid
    logic DZ; // divide by zero
    logic OF; // overflow
    logic UF; // underflow
    logic NX; // inexact
  } status_t;

endpackage

// File: rtl/fpu_rb_pkg.sv
// Shared constants for the FPU result buffer.
package fpu_rb_pkg;

  localparam int unsigned FflagsWidth  = 5;
  localparam int unsigned DefaultDepth = 4;

  // Flatten a status word into the {NV,DZ,OF,UF,NX} flag vector.
  function automatic logic [FflagsWidth-1:0] status_bits(input fpnew_pkg::status_t s);
    return s;
  endfunction

endpackage

// File: rtl/fpu_rb_store.sv
// Circular result store: registered read port, push/pop/count, flush empties it.
module fpu_rb_store
  import fpu_rb_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter type         EntryT = logic,
  localparam int unsigned CntW  = $clog2(DEPTH + 1),
  localparam int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  EntryT           data_i,
  input  logic            pop_i,
  output EntryT           data_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  EntryT           mem [DEPTH];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [CntW-1:0] count;
  logic            push_ok;
  logic            pop_ok;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A push at full is only taken when a pop frees the head in the same cycle.
  assign pop_ok  = pop_i && (count != '0) && !flush_i;
  assign push_ok = push_i && !flush_i && ((count != CntW'(DEPTH)) || pop_ok);

  assign data_o  = mem[rptr];
  assign empty_o = (count == '0);
  assign full_o  = (count == CntW'(DEPTH));
  assign count_o = count;

  // Payload storage, not reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= next_ptr(wptr);
      if (pop_ok)  rptr <= next_ptr(rptr);
      count <= count + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

endmodule

// File: rtl/fpu_result_buffer.sv
// Credit-based result buffer between an FPU without backpressure and writeback.
module fpu_result_buffer
  import fpu_rb_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = DefaultDepth,
  parameter type         TagType = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic                   fpu_valid_i,
  input  logic [WIDTH-1:0]       fpu_result_i,
  input  fpnew_pkg::status_t     fpu_status_i,
  input  TagType                 fpu_tag_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [WIDTH-1:0]       wb_result_o,
  output fpnew_pkg::status_t     wb_status_o,
  output TagType                 wb_tag_o,
  output logic [FflagsWidth-1:0] fflags_o,
  input  logic                   fflags_clr_i,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0]   result;
    fpnew_pkg::status_t status;
    TagType             tag;
  } entry_t;

  entry_t           push_data;
  entry_t           head;
  logic             empty;
  logic             full;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  inflight;
  logic [CntW:0]    occupancy;
  logic             issue_hs;
  logic             wb_hs;
  logic [FflagsWidth-1:0] fflags;
  logic             overflow;

  assign push_data = '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};

  fpu_rb_store #(
    .DEPTH  (DEPTH),
    .EntryT (entry_t)
  ) u_store (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (fpu_valid_i),
    .data_i  (push_data),
    .pop_i   (wb_hs),
    .data_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  // Credits cover both stored entries and ops still inside the FPU.
  assign occupancy     = {1'b0, count} + {1'b0, inflight};
  assign issue_ready_o = (occupancy < (CntW + 1)'(DEPTH)) && !flush_i;
  assign issue_hs      = issue_valid_i && issue_ready_o;

  assign wb_valid_o  = !empty;
  assign wb_hs       = wb_valid_o && wb_ready_i;
  assign wb_result_o = head.result;
  assign wb_status_o = head.status;
  assign wb_tag_o    = head.tag;

  assign fflags_o   = fflags;
  assign overflow_o = overflow;
  assign busy_o     = (inflight != '0) || !empty;

  // In-flight credit counter; never decrements below zero on a stray result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + CntW'(issue_hs) - CntW'(fpu_valid_i && (inflight != '0));
    end
  end

  // Accrued flags and sticky overflow; flush leaves both alone.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fflags   <= '0;
      overflow <= 1'b0;
    end else begin
      fflags <= (fflags_clr_i ? '0 : fflags) | (wb_hs ? status_bits(wb_status_o) : '0);
      if (fpu_valid_i && !flush_i && full && !wb_hs) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Table-driven bench for fpu_result_buffer (WIDTH=16, DEPTH=4, 4-bit tags).
module tb_fpu_result_buffer;

  localparam int unsigned Width = 16;
  localparam int unsigned Depth = 4;
  typedef logic [3:0] tag_t;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               flush_i;
  logic               issue_valid_i;
  logic               issue_ready_o;
  logic               fpu_valid_i;
  logic [Width-1:0]   fpu_result_i;
  fpnew_pkg::status_t fpu_status_i;
  tag_t               fpu_tag_i;
  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [Width-1:0]   wb_result_o;
  fpnew_pkg::status_t wb_status_o;
  tag_t               wb_tag_o;
  logic [4:0]         fflags_o;
  logic               fflags_clr_i;
  logic               busy_o;
  logic               overflow_o;

  fpu_result_buffer #(
    .WIDTH   (Width),
    .DEPTH   (Depth),
    .TagType (tag_t)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .fpu_valid_i   (fpu_valid_i),
    .fpu_result_i  (fpu_result_i),
    .fpu_status_i  (fpu_status_i),
    .fpu_tag_i     (fpu_tag_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_result_o   (wb_result_o),
    .wb_status_o   (wb_status_o),
    .wb_tag_o      (wb_tag_o),
    .fflags_o      (fflags_o),
    .fflags_clr_i  (fflags_clr_i),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       issue;
    logic       fv;
    tag_t       tag;
    logic [4:0] st;
    logic       wbr;
    logic       clr;
    logic       flush;
    logic       rdy;
    logic       wbv;
    tag_t       wtag;
    logic       busy;
    logic [4:0] ff;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input logic issue, input logic fv, input tag_t tag,
                              input logic [4:0] st, input logic wbr, input logic clr,
                              input logic flush, input logic rdy, input logic wbv,
                              input tag_t wtag, input logic busy, input logic [4:0] ff,
                              input logic ovf);
    vec_t v;
    v.issue = issue; v.fv = fv; v.tag = tag; v.st = st; v.wbr = wbr; v.clr = clr;
    v.flush = flush; v.rdy = rdy; v.wbv = wbv; v.wtag = wtag; v.busy = busy;
    v.ff = ff; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush_i = 1'b0; issue_valid_i = 1'b0; fpu_valid_i = 1'b0; fpu_result_i = '0;
    fpu_status_i = '0; fpu_tag_i = '0; wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
  endtask

  task automatic push_tag(input tag_t t);
    fpu_valid_i = 1'b1; fpu_tag_i = t; fpu_result_i = {t, t, t, t};
  endtask

  initial begin
    logic prev_wbv;
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    check("reset_wb_valid", 32'(wb_valid_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_ready", 32'(issue_ready_o), 32'd1);
    check("reset_fflags", 32'(fflags_o), 32'd0);
    check("reset_overflow", 32'(overflow_o), 32'd0);

    //  iss fv tag st       wbr clr fl   rdy wbv wtag busy ff       ovf
    // credit limit
    add(1, 0, 0, 5'h00, 0, 0, 0,  1, 0, 0, 1, 5'h00, 0);
    add(1, 0, 0, 5'h00, 0, 0, 0,  1, 0, 0, 1, 5'h00, 0);
    add(1, 0, 0, 5'h00, 0, 0, 0,  1, 0, 0, 1, 5'h00, 0);
    add(1, 0, 0, 5'h00, 0, 0, 0,  0, 0, 0, 1, 5'h00, 0);
    add(1, 0, 0, 5'h00, 0, 0, 0,  0, 0, 0, 1, 5'h00, 0);
    add(0, 1, 1, 5'h01, 0, 0, 0,  0, 1, 1, 1, 5'h00, 0);
    add(0, 1, 2, 5'h04, 0, 0, 0,  0, 1, 1, 1, 5'h00, 0);
    add(0, 1, 3, 5'h00, 0, 0, 0,  0, 1, 1, 1, 5'h00, 0);
    add(0, 1, 4, 5'h08, 0, 0, 0,  0, 1, 1, 1, 5'h00, 0);
    // full with simultaneous push/pop, then push alone at full
    add(0, 1, 5, 5'h00, 1, 0, 0,  0, 1, 2, 1, 5'h01, 0);
    add(0, 1, 6, 5'h00, 0, 0, 0,  0, 1, 2, 1, 5'h01, 1);
    // flag accrual, clear coincident with DZ handshake
    add(0, 0, 0, 5'h00, 1, 0, 0,  1, 1, 3, 1, 5'h05, 1);
    add(0, 0, 0, 5'h00, 1, 0, 0,  1, 1, 4, 1, 5'h05, 1);
    add(0, 0, 0, 5'h00, 1, 1, 0,  1, 1, 5, 1, 5'h08, 1);
    add(0, 0, 0, 5'h00, 1, 0, 0,  1, 0, 0, 0, 5'h08, 1);
    // ordering: three back-to-back results drained one per cycle
    add(1, 0, 0, 5'h00, 0, 0, 0,  1, 0, 0, 1, 5'h08, 1);
    add(1, 0, 0, 5'h00, 0, 0, 0,  1, 0, 0, 1, 5'h08, 1);
    add(1, 0, 0, 5'h00, 0, 0, 0,  1, 0, 0, 1, 5'h08, 1);
    add(0, 1, 7, 5'h00, 1, 0, 0,  1, 1, 7, 1, 5'h08, 1);
    add(0, 1, 8, 5'h00, 1, 0, 0,  1, 1, 8, 1, 5'h08, 1);
    add(0, 1, 9, 5'h00, 1, 0, 0,  1, 1, 9, 1, 5'h08, 1);
    add(0, 0, 0, 5'h00, 1, 0, 0,  1, 0, 0, 0, 5'h08, 1);
    // flush with 2 stored and 1 in flight, plus same-cycle push and issue
    add(1, 0, 0,  5'h00, 0, 0, 0, 1, 0, 0, 1, 5'h08, 1);
    add(1, 0, 0,  5'h00, 0, 0, 0, 1, 0, 0, 1, 5'h08, 1);
    add(1, 0, 0,  5'h00, 0, 0, 0, 1, 0, 0, 1, 5'h08, 1);
    add(0, 1, 10, 5'h02, 0, 0, 0, 1, 1, 10, 1, 5'h08, 1);
    add(0, 1, 11, 5'h00, 0, 0, 0, 1, 1, 10, 1, 5'h08, 1);
    add(1, 1, 12, 5'h00, 0, 0, 1, 1, 0, 0, 0, 5'h08, 1);
    add(0, 0, 0,  5'h00, 0, 0, 0, 1, 0, 0, 0, 5'h08, 1);

    prev_wbv = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      issue_valid_i = v.issue; wb_ready_i = v.wbr; fflags_clr_i = v.clr; flush_i = v.flush;
      fpu_valid_i = v.fv; fpu_tag_i = v.tag; fpu_result_i = {v.tag, v.tag, v.tag, v.tag};
      fpu_status_i = v.st;
      #1;
      // a push must not show up on the head in its own cycle
      check($sformatf("v%0d_no_fallthrough", i), 32'(wb_valid_o), 32'(prev_wbv));
      @(posedge clk_i);
      #1 idle();
      #1;
      check($sformatf("v%0d_issue_ready", i), 32'(issue_ready_o), 32'(v.rdy));
      check($sformatf("v%0d_wb_valid", i), 32'(wb_valid_o), 32'(v.wbv));
      check($sformatf("v%0d_busy", i), 32'(busy_o), 32'(v.busy));
      check($sformatf("v%0d_fflags", i), 32'(fflags_o), 32'(v.ff));
      check($sformatf("v%0d_overflow", i), 32'(overflow_o), 32'(v.ovf));
      if (v.wbv) begin
        check($sformatf("v%0d_wb_tag", i), 32'(wb_tag_o), 32'(v.wtag));
        check($sformatf("v%0d_wb_result", i), 32'(wb_result_o),
              32'({v.wtag, v.wtag, v.wtag, v.wtag}));
      end
      prev_wbv = v.wbv;
    end

    // stall hold: head stays stable while not accepted
    push_tag(4'd13);
    fpu_status_i = 5'h10;
    @(posedge clk_i);
    #1 idle();
    repeat (3) @(posedge clk_i);
    #1;
    check("stall_wb_valid", 32'(wb_valid_o), 32'd1);
    check("stall_wb_tag", 32'(wb_tag_o), 32'd13);
    check("stall_wb_status", 32'(wb_status_o), 32'h10);

    // reset mid-stream with 3 stored
    push_tag(4'd14);
    @(posedge clk_i);
    #1 push_tag(4'd15);
    @(posedge clk_i);
    #1 idle();
    #1;
    check("pre_reset_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    check("midreset_wb_valid", 32'(wb_valid_o), 32'd0);
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_ready", 32'(issue_ready_o), 32'd1);
    check("midreset_fflags", 32'(fflags_o), 32'd0);
    check("midreset_overflow", 32'(overflow_o), 32'd0);
    wb_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("post_reset_no_stale", 32'(wb_valid_o), 32'd0);
    check("post_reset_fflags", 32'(fflags_o), 32'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
